// File: rtl/axi4_lite_write_arbiter.sv
// Round-robin arbiter that shares one AXI4-Lite write slave among several write masters.
// Out-of-window addresses are completed locally with DECERR; one transaction is in flight at a time.
module axi4_lite_write_arbiter #(
  parameter int unsigned NUM_MASTERS   = 2,
  parameter int unsigned ADDRESS_WIDTH = 32,
  parameter int unsigned DATA_WIDTH    = 32,
  parameter logic [ADDRESS_WIDTH-1:0] MIN_ADDRESS = 'h01,
  parameter logic [ADDRESS_WIDTH-1:0] MAX_ADDRESS = 'hff
) (
  input  logic                                aclk,
  input  logic                                aresetn,
  input  logic [NUM_MASTERS-1:0]              s_awvalid,
  output logic [NUM_MASTERS-1:0]              s_awready,
  input  logic [NUM_MASTERS*ADDRESS_WIDTH-1:0] s_awaddr,
  input  logic [NUM_MASTERS*3-1:0]            s_awprot,
  input  logic [NUM_MASTERS-1:0]              s_wvalid,
  output logic [NUM_MASTERS-1:0]              s_wready,
  input  logic [NUM_MASTERS*DATA_WIDTH-1:0]   s_wdata,
  input  logic [NUM_MASTERS*DATA_WIDTH/8-1:0] s_wstrb,
  output logic [NUM_MASTERS-1:0]              s_bvalid,
  output logic [NUM_MASTERS*2-1:0]            s_bresp,
  input  logic [NUM_MASTERS-1:0]              s_bready,
  output logic                                m_awvalid,
  input  logic                                m_awready,
  output logic [ADDRESS_WIDTH-1:0]            m_awaddr,
  output logic [2:0]                          m_awprot,
  output logic                                m_wvalid,
  input  logic                                m_wready,
  output logic [DATA_WIDTH-1:0]               m_wdata,
  output logic [DATA_WIDTH/8-1:0]             m_wstrb,
  input  logic                                m_bvalid,
  input  logic [1:0]                          m_bresp,
  output logic                                m_bready
);

  localparam int unsigned GW = (NUM_MASTERS > 1) ? $clog2(NUM_MASTERS) : 1;
  localparam int unsigned SW = DATA_WIDTH / 8;

  typedef enum logic [2:0] {IDLE, FWD, RESP, ERR_W, ERR_B} state_t;

  state_t          state, state_next;
  logic [GW-1:0]   grant, last_grant;
  logic            aw_done, w_done;
  logic            aw_hs, w_hs;
  logic            winner_found;
  logic [GW-1:0]   winner, cand;
  int unsigned     idx;
  logic [ADDRESS_WIDTH-1:0] winner_addr;
  logic            in_range;

  // Scan starts one past the previous winner so every requester gets a turn.
  always_comb begin
    winner_found = 1'b0;
    winner       = '0;
    idx          = 0;
    cand         = '0;
    for (int unsigned i = 1; i <= NUM_MASTERS; i++) begin
      idx  = (32'(last_grant) + i) % NUM_MASTERS;
      cand = GW'(idx);
      if (!winner_found && s_awvalid[cand]) begin
        winner_found = 1'b1;
        winner       = cand;
      end
    end
  end

  assign winner_addr = s_awaddr[winner*ADDRESS_WIDTH +: ADDRESS_WIDTH];
  assign in_range    = (winner_addr >= MIN_ADDRESS) && (winner_addr <= MAX_ADDRESS);

  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      state      <= IDLE;
      grant      <= '0;
      last_grant <= GW'(NUM_MASTERS - 1);
      aw_done    <= 1'b0;
      w_done     <= 1'b0;
    end else begin
      state <= state_next;
      if (state == IDLE) begin
        if (winner_found) begin
          grant      <= winner;
          last_grant <= winner;
        end
        aw_done <= 1'b0;
        w_done  <= 1'b0;
      end else begin
        aw_done <= aw_done | aw_hs;
        w_done  <= w_done | w_hs;
      end
    end
  end

  always_comb begin
    state_next = state;
    aw_hs      = 1'b0;
    w_hs       = 1'b0;
    s_awready  = '0;
    s_wready   = '0;
    s_bvalid   = '0;
    s_bresp    = '0;
    m_awvalid  = 1'b0;
    m_awaddr   = '0;
    m_awprot   = '0;
    m_wvalid   = 1'b0;
    m_wdata    = '0;
    m_wstrb    = '0;
    m_bready   = 1'b0;
    case (state)
      IDLE: begin
        if (winner_found) state_next = in_range ? FWD : ERR_W;
      end
      FWD: begin
        m_awvalid        = s_awvalid[grant] & ~aw_done;
        m_wvalid         = s_wvalid[grant] & ~w_done;
        s_awready[grant] = m_awready & ~aw_done;
        s_wready[grant]  = m_wready & ~w_done;
        m_awaddr         = s_awaddr[grant*ADDRESS_WIDTH +: ADDRESS_WIDTH];
        m_awprot         = s_awprot[grant*3 +: 3];
        m_wdata          = s_wdata[grant*DATA_WIDTH +: DATA_WIDTH];
        m_wstrb          = s_wstrb[grant*SW +: SW];
        aw_hs            = m_awvalid & m_awready;
        w_hs             = m_wvalid & m_wready;
        if ((aw_done | aw_hs) & (w_done | w_hs)) state_next = RESP;
      end
      RESP: begin
        s_bvalid[grant]        = m_bvalid;
        s_bresp[grant*2 +: 2]  = m_bresp;
        m_bready               = s_bready[grant];
        if (m_bvalid & s_bready[grant]) state_next = IDLE;
      end
      ERR_W: begin
        s_awready[grant] = ~aw_done;
        s_wready[grant]  = ~w_done;
        aw_hs            = s_awvalid[grant] & ~aw_done;
        w_hs             = s_wvalid[grant] & ~w_done;
        if ((aw_done | aw_hs) & (w_done | w_hs)) state_next = ERR_B;
      end
      ERR_B: begin
        s_bvalid[grant]       = 1'b1;
        s_bresp[grant*2 +: 2] = 2'b11;
        if (s_bready[grant]) state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

endmodule

// File: tb/tb_axi4_lite_write_arbiter.sv
// Directed bench for axi4_lite_write_arbiter with two masters: forwarding, round-robin,
// local DECERR, W-before-AW, response backpressure and reset in the middle of a response.
module tb_axi4_lite_write_arbiter;
  localparam int N  = 2;
  localparam int AW = 32;
  localparam int DW = 32;

  logic              aclk = 1'b0;
  logic              aresetn = 1'b0;
  logic [N-1:0]      s_awvalid, s_awready, s_wvalid, s_wready, s_bvalid, s_bready;
  logic [N*AW-1:0]   s_awaddr;
  logic [N*3-1:0]    s_awprot;
  logic [N*DW-1:0]   s_wdata;
  logic [N*DW/8-1:0] s_wstrb;
  logic [N*2-1:0]    s_bresp;
  logic              m_awvalid, m_awready, m_wvalid, m_wready, m_bvalid, m_bready;
  logic [AW-1:0]     m_awaddr;
  logic [2:0]        m_awprot;
  logic [DW-1:0]     m_wdata;
  logic [DW/8-1:0]   m_wstrb;
  logic [1:0]        m_bresp;

  int errors = 0;
  int checks = 0;

  axi4_lite_write_arbiter #(
    .NUM_MASTERS(N), .ADDRESS_WIDTH(AW), .DATA_WIDTH(DW),
    .MIN_ADDRESS(32'h01), .MAX_ADDRESS(32'hff)
  ) dut (
    .aclk(aclk), .aresetn(aresetn),
    .s_awvalid(s_awvalid), .s_awready(s_awready), .s_awaddr(s_awaddr), .s_awprot(s_awprot),
    .s_wvalid(s_wvalid), .s_wready(s_wready), .s_wdata(s_wdata), .s_wstrb(s_wstrb),
    .s_bvalid(s_bvalid), .s_bresp(s_bresp), .s_bready(s_bready),
    .m_awvalid(m_awvalid), .m_awready(m_awready), .m_awaddr(m_awaddr), .m_awprot(m_awprot),
    .m_wvalid(m_wvalid), .m_wready(m_wready), .m_wdata(m_wdata), .m_wstrb(m_wstrb),
    .m_bvalid(m_bvalid), .m_bresp(m_bresp), .m_bready(m_bready)
  );

  always #5 aclk = ~aclk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge aclk);
    #1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    s_awvalid = '0; s_wvalid = '0; s_bready = '0;
    s_awaddr = '0; s_awprot = '0; s_wdata = '0; s_wstrb = '0;
    m_awready = 1'b0; m_wready = 1'b0; m_bvalid = 1'b0; m_bresp = 2'b00;

    // Reset state
    #12;
    chk("rst_m_awvalid", m_awvalid, 0);
    chk("rst_m_wvalid", m_wvalid, 0);
    chk("rst_m_bready", m_bready, 0);
    chk("rst_s_awready", s_awready, 0);
    chk("rst_s_bvalid", s_bvalid, 0);
    tick();
    aresetn = 1'b1;

    // Single master 0 transaction, OKAY
    s_awvalid = 2'b01; s_wvalid = 2'b01;
    s_awaddr[0 +: AW] = 32'h10; s_awprot[0 +: 3] = 3'b010;
    s_wdata[0 +: DW] = 32'hA5A5A5A5; s_wstrb[0 +: 4] = 4'hF;
    m_awready = 1'b1; m_wready = 1'b1;
    #1;
    chk("t1_idle_m_awvalid", m_awvalid, 0);
    tick();
    chk("t1_m_awvalid", m_awvalid, 1);
    chk("t1_m_awaddr", m_awaddr, 32'h10);
    chk("t1_m_awprot", m_awprot, 3'b010);
    chk("t1_m_wdata", m_wdata, 32'hA5A5A5A5);
    chk("t1_m_wstrb", m_wstrb, 4'hF);
    chk("t1_s_awready", s_awready, 2'b01);
    chk("t1_s_wready", s_wready, 2'b01);
    tick();
    s_awvalid = '0; s_wvalid = '0;
    m_bvalid = 1'b1; m_bresp = 2'b00; s_bready = 2'b01;
    #1;
    chk("t1_s_bvalid", s_bvalid, 2'b01);
    chk("t1_s_bresp", s_bresp, 4'b0000);
    chk("t1_m_bready", m_bready, 1);
    tick();
    m_bvalid = 1'b0;
    #1;
    chk("t1_done_s_bvalid", s_bvalid, 0);

    // Reset so master 0 wins the first contention again
    aresetn = 1'b0;
    #1;
    chk("rst2_s_bvalid", s_bvalid, 0);
    tick();
    aresetn = 1'b1;

    // Round-robin: both masters request continuously, 4 transactions each
    s_awvalid = 2'b11; s_wvalid = 2'b11;
    s_awaddr[0 +: AW] = 32'h20; s_awaddr[AW +: AW] = 32'h30;
    m_awready = 1'b1; m_wready = 1'b1; m_bvalid = 1'b1; m_bresp = 2'b00; s_bready = 2'b11;
    for (int k = 0; k < 8; k++) begin
      logic [1:0] oh;
      oh = (k % 2 == 0) ? 2'b01 : 2'b10;
      tick();
      chk("rr_m_awaddr", m_awaddr, (k % 2 == 0) ? 32'h20 : 32'h30);
      chk("rr_s_awready", s_awready, oh);
      tick();
      chk("rr_s_bvalid", s_bvalid, oh);
      tick();
      chk("rr_idle_m_awvalid", m_awvalid, 0);
    end

    // Master 1 out-of-range address: local DECERR
    s_awvalid = 2'b10; s_wvalid = 2'b10;
    s_awaddr[AW +: AW] = 32'h100;
    m_bvalid = 1'b0; s_bready = 2'b00;
    #1;
    chk("err_idle_m_awvalid", m_awvalid, 0);
    tick();
    chk("err_w_m_awvalid", m_awvalid, 0);
    chk("err_w_s_awready", s_awready, 2'b10);
    chk("err_w_s_wready", s_wready, 2'b10);
    tick();
    s_awvalid = '0; s_wvalid = '0;
    #1;
    chk("err_b_s_bvalid", s_bvalid, 2'b10);
    chk("err_b_s_bresp", s_bresp, 4'b1100);
    chk("err_b_m_awvalid", m_awvalid, 0);
    tick();
    chk("err_b_hold_s_bvalid", s_bvalid, 2'b10);
    s_bready = 2'b10;
    tick();
    chk("err_done_s_bvalid", s_bvalid, 0);
    s_bready = 2'b00;

    // W presented 3 cycles before AW
    s_wvalid = 2'b01; s_wdata[0 +: DW] = 32'h12345678; s_wstrb[0 +: 4] = 4'h3;
    m_awready = 1'b1; m_wready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      #1;
      chk("wfirst_s_wready", s_wready, 0);
      chk("wfirst_m_wvalid", m_wvalid, 0);
      tick();
    end
    s_awvalid = 2'b01; s_awaddr[0 +: AW] = 32'h40; s_awprot[0 +: 3] = 3'b000;
    #1;
    chk("wfirst_idle_s_wready", s_wready, 0);
    tick();
    chk("wfirst_m_awvalid", m_awvalid, 1);
    chk("wfirst_m_wvalid", m_wvalid, 1);
    chk("wfirst_m_awaddr", m_awaddr, 32'h40);
    chk("wfirst_m_wdata", m_wdata, 32'h12345678);
    chk("wfirst_m_wstrb", m_wstrb, 4'h3);
    chk("wfirst_s_wready_stall", s_wready, 0);
    tick();
    s_awvalid = '0; m_wready = 1'b1;
    #1;
    chk("wfirst_aw_done_m_awvalid", m_awvalid, 0);
    chk("wfirst_w_m_wvalid", m_wvalid, 1);
    chk("wfirst_s_wready", s_wready, 2'b01);
    tick();
    s_wvalid = '0;

    // Slave response SLVERR held off by master backpressure for 5 cycles
    m_bvalid = 1'b1; m_bresp = 2'b10; s_bready = 2'b00;
    for (int i = 0; i < 5; i++) begin
      #1;
      chk("bp_m_bready", m_bready, 0);
      chk("bp_s_bvalid", s_bvalid, 2'b01);
      chk("bp_s_bresp", s_bresp, 4'b0010);
      tick();
    end
    s_bready = 2'b01;
    #1;
    chk("bp_release_m_bready", m_bready, 1);
    tick();
    m_bvalid = 1'b0; s_bready = 2'b00;
    #1;
    chk("bp_done_s_bvalid", s_bvalid, 0);
    chk("bp_done_m_bready", m_bready, 0);

    // Reset asserted while in RESP
    s_awvalid = 2'b01; s_wvalid = 2'b01; s_awaddr[0 +: AW] = 32'h60;
    m_awready = 1'b1; m_wready = 1'b1;
    tick();
    tick();
    s_awvalid = '0; s_wvalid = '0;
    m_bvalid = 1'b1; m_bresp = 2'b00; s_bready = 2'b00;
    #1;
    chk("rstresp_pre_s_bvalid", s_bvalid, 2'b01);
    aresetn = 1'b0;
    #1;
    chk("rstresp_s_bvalid", s_bvalid, 0);
    chk("rstresp_m_bready", m_bready, 0);
    chk("rstresp_s_awready", s_awready, 0);
    chk("rstresp_m_awvalid", m_awvalid, 0);
    m_bvalid = 1'b0;
    tick();
    aresetn = 1'b1;
    s_awvalid = 2'b10; s_wvalid = 2'b10;
    s_awaddr[AW +: AW] = 32'h50; s_wdata[DW +: DW] = 32'hCAFEF00D;
    #1;
    chk("post_rst_idle_m_awvalid", m_awvalid, 0);
    tick();
    chk("post_rst_m_awvalid", m_awvalid, 1);
    chk("post_rst_m_awaddr", m_awaddr, 32'h50);
    chk("post_rst_m_wdata", m_wdata, 32'hCAFEF00D);
    chk("post_rst_s_awready", s_awready, 2'b10);
    tick();
    s_awvalid = '0; s_wvalid = '0;
    m_bvalid = 1'b1; s_bready = 2'b10;
    #1;
    chk("post_rst_s_bvalid", s_bvalid, 2'b10);
    tick();
    m_bvalid = 1'b0; s_bready = 2'b00;
    #1;
    chk("post_rst_done_s_bvalid", s_bvalid, 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
